// File: rtl/xge_reset_seq.sv
// xge_reset_seq: staggered active-low reset sequencer for the MAC clock domains.
// All domains are held low for ASSERT_CYCLES, then released one by one in index
// order, STAGGER_CYCLES apart. sw_rst_req re-runs the whole sequence; dom_mask
// holds individual domains in reset without disturbing the release schedule.
// Optional macro XGE_RST_SEQ_ACK_EN adds per-domain acknowledge gating with a
// timeout (dom_ack input, sticky seq_err output).
module xge_reset_seq #(
  parameter int NUM_DOMAINS    = 3,
  parameter int ASSERT_CYCLES  = 8,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] dom_mask,
`ifdef XGE_RST_SEQ_ACK_EN
  input  logic [NUM_DOMAINS-1:0] dom_ack,
  output logic                   seq_err,
`endif
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic [7:0]             seq_count
);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0] FIRST_STAG   = IDX_W'(1);

  // Out-of-range parameter sets elaborate this clearly named empty scope, which
  // makes a bad build easy to spot in the hierarchy.
  generate
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 32 || ASSERT_CYCLES < 1 ||
        STAGGER_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        CNT_W < $clog2(ASSERT_CYCLES + STAGGER_CYCLES + 1)) begin : g_illegal_parameters
    end
  endgenerate

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] released_q, released_d;
  logic [NUM_DOMAINS-1:0] rst_n_q;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [7:0]             count_q, count_d;
  logic [NUM_DOMAINS-1:0] idx_onehot;

`ifdef XGE_RST_SEQ_ACK_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0]       wait_q, wait_d;
  logic                   err_q, err_d;
  logic [NUM_DOMAINS-1:0] ack_vec;
  logic                   prev_acked;
  logic                   last_acked;
  logic                   tmo_hit;

  // A masked domain never comes out of reset, so it can never acknowledge;
  // treat it as acked so the rest of the sequence is not stalled by it.
  always_comb begin
    ack_vec    = dom_ack | dom_mask;
    prev_acked = |(ack_vec & (NUM_DOMAINS'(1) << (idx_q - FIRST_STAG)));
    last_acked = ack_vec[NUM_DOMAINS-1];
    tmo_hit    = (wait_q >= TMO_LAST);
  end
`endif

  assign idx_onehot = NUM_DOMAINS'(1) << idx_q;

  // Next-state logic: pulse-width count, staggered release and completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    released_d = released_q;
    done_d     = done_q;
    busy_d     = busy_q;
    count_d    = count_q;
`ifdef XGE_RST_SEQ_ACK_EN
    wait_d     = wait_q;
    err_d      = err_q;
`endif
    if (sw_rst_req) begin
      state_d    = ST_ASSERT;
      cnt_d      = '0;
      idx_d      = '0;
      released_d = '0;
      done_d     = 1'b0;
      busy_d     = 1'b1;
`ifdef XGE_RST_SEQ_ACK_EN
      wait_d     = '0;
      err_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ASSERT: begin
          released_d = '0;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == ASSERT_LAST) begin
            released_d[0] = 1'b1;
            cnt_d         = '0;
            idx_d         = FIRST_STAG;
            state_d       = (NUM_DOMAINS == 1) ? ST_DONE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
`ifdef XGE_RST_SEQ_ACK_EN
          // The stagger slot has elapsed; hold the count until the previous
          // domain acknowledges or the wait times out.
          if (cnt_q >= STAGGER_LAST) begin
            if (prev_acked || tmo_hit) begin
              released_d = released_q | idx_onehot;
              cnt_d      = '0;
              wait_d     = '0;
              if (!prev_acked) err_d = 1'b1;
              if (idx_q == LAST_IDX) state_d = ST_DONE;
              else                   idx_d   = idx_q + IDX_W'(1);
            end else begin
              wait_d = wait_q + TMO_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == STAGGER_LAST) begin
            released_d = released_q | idx_onehot;
            cnt_d      = '0;
            if (idx_q == LAST_IDX) state_d = ST_DONE;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
`endif
        end
        ST_DONE: begin
`ifdef XGE_RST_SEQ_ACK_EN
          if (!done_q) begin
            if (last_acked || tmo_hit) begin
              done_d = 1'b1;
              busy_d = 1'b0;
              wait_d = '0;
              if (!last_acked) err_d = 1'b1;
              if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end else begin
              wait_d = wait_q + TMO_W'(1);
            end
          end
`else
          // done_q rising marks entry; the completed-sequence count bumps once.
          if (!done_q) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
          end
`endif
        end
        default: begin
          state_d    = ST_ASSERT;
          cnt_d      = '0;
          idx_d      = '0;
          released_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
        end
      endcase
    end
  end

  // State registers; the domain resets take the mask directly so a mask change
  // shows on the very next edge in any state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      released_q <= '0;
      rst_n_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      count_q    <= '0;
`ifdef XGE_RST_SEQ_ACK_EN
      wait_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      released_q <= released_d;
      rst_n_q    <= released_d & ~dom_mask;
      done_q     <= done_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
`ifdef XGE_RST_SEQ_ACK_EN
      wait_q     <= wait_d;
      err_q      <= err_d;
`endif
    end
  end

  assign rst_n_o   = rst_n_q;
  assign seq_busy  = busy_q;
  assign seq_done  = done_q;
  assign seq_count = count_q;
`ifdef XGE_RST_SEQ_ACK_EN
  assign seq_err   = err_q;
`endif

endmodule

// File: tb/tb_xge_reset_seq.sv
// Directed bench for xge_reset_seq (default parameters, 3 domains).
// Expected outputs are queued with each stimulus step and checked when the
// bench reaches the edge at which the DUT must present them.
module tb_xge_reset_seq;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       sw_rst_req;
  logic [2:0] dom_mask;
  logic [2:0] rst_n_o;
  logic       seq_busy;
  logic       seq_done;
  logic [7:0] seq_count;
`ifdef XGE_RST_SEQ_ACK_EN
  logic [2:0] dom_ack;
  logic       seq_err;
`endif

  int tests  = 0;
  int failed = 0;
  int e      = 0;

  typedef struct {
    string      tag;
    logic [2:0] rst;
    logic       done;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  xge_reset_seq dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .sw_rst_req(sw_rst_req),
    .dom_mask  (dom_mask),
`ifdef XGE_RST_SEQ_ACK_EN
    .dom_ack   (dom_ack),
    .seq_err   (seq_err),
`endif
    .rst_n_o   (rst_n_o),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .seq_count (seq_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    e++;
  endtask

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (e < n && guard < 5000) begin
      tick();
      guard++;
    end
    tests++;
    assert (e == n) else begin
      failed++;
      $error("FAIL goto edge=%0d expected edge=%0d", e, n);
    end
  endtask

  task automatic check();
    exp_t x;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL scoreboard_empty got=0 entries expected>=1");
      return;
    end
    x = sb.pop_front();
    tests += 4;
    assert (rst_n_o === x.rst) else begin
      failed++;
      $error("FAIL %s rst_n_o got=%b expected=%b (edge %0d)", x.tag, rst_n_o, x.rst, e);
    end
    assert (seq_done === x.done) else begin
      failed++;
      $error("FAIL %s seq_done got=%b expected=%b (edge %0d)", x.tag, seq_done, x.done, e);
    end
    assert (seq_busy === x.busy) else begin
      failed++;
      $error("FAIL %s seq_busy got=%b expected=%b (edge %0d)", x.tag, seq_busy, x.busy, e);
    end
    assert (seq_count === x.cnt) else begin
      failed++;
      $error("FAIL %s seq_count got=%0d expected=%0d (edge %0d)", x.tag, seq_count, x.cnt, e);
    end
    $display("[TB] edge %0d %s rst_n_o=%b done=%b busy=%b count=%0d", e, x.tag,
             rst_n_o, seq_done, seq_busy, seq_count);
  endtask

  // Queue an expectation, run to the edge where it must hold, then compare.
  task automatic expect_at(input int n, input string tag, input logic [2:0] r,
                           input logic d, input logic b, input logic [7:0] c);
    exp_t x;
    x.tag = tag; x.rst = r; x.done = d; x.busy = b; x.cnt = c;
    sb.push_back(x);
    goto(n);
    check();
  endtask

  initial begin
    wb_rst_i   = 1'b1;
    sw_rst_req = 1'b0;
    dom_mask   = 3'b000;
`ifdef XGE_RST_SEQ_ACK_EN
    dom_ack    = 3'b111;
`endif
    repeat (3) tick();
    e = 0;
    expect_at(0, "reset", 3'b000, 1'b0, 1'b1, 8'd0);

    // Plain sequence: edge 1 is the first edge with wb_rst_i low.
    wb_rst_i = 1'b0;
    expect_at(7,  "pre_release", 3'b000, 1'b0, 1'b1, 8'd0);
    expect_at(8,  "dom0_up",     3'b001, 1'b0, 1'b1, 8'd0);
    expect_at(11, "dom0_only",   3'b001, 1'b0, 1'b1, 8'd0);
    expect_at(12, "dom1_up",     3'b011, 1'b0, 1'b1, 8'd0);
    expect_at(15, "dom1_only",   3'b011, 1'b0, 1'b1, 8'd0);
    expect_at(16, "dom2_up",     3'b111, 1'b0, 1'b1, 8'd0);
    expect_at(17, "done",        3'b111, 1'b1, 1'b0, 8'd1);

    // Software request from DONE, with domain 1 masked for the new sequence.
    goto(39);
    sw_rst_req = 1'b1;
    dom_mask   = 3'b010;
    expect_at(40, "swreq_assert", 3'b000, 1'b0, 1'b1, 8'd1);
    sw_rst_req = 1'b0;
    expect_at(48, "mask_dom0",    3'b001, 1'b0, 1'b1, 8'd1);
    expect_at(52, "mask_dom1_lo", 3'b001, 1'b0, 1'b1, 8'd1);
    expect_at(56, "mask_dom2",    3'b101, 1'b0, 1'b1, 8'd1);
    expect_at(57, "mask_done",    3'b101, 1'b1, 1'b0, 8'd2);
    goto(59);
    dom_mask = 3'b000;
    expect_at(60, "unmask",       3'b111, 1'b1, 1'b0, 8'd2);
    dom_mask = 3'b100;
    expect_at(61, "mask_in_done", 3'b011, 1'b1, 1'b0, 8'd2);
    dom_mask = 3'b000;

    // Second request during ASSERT restarts the pulse-width count.
    goto(69);
    sw_rst_req = 1'b1;
    expect_at(70, "req_a", 3'b000, 1'b0, 1'b1, 8'd2);
    sw_rst_req = 1'b0;
    goto(74);
    sw_rst_req = 1'b1;
    expect_at(75, "req_b", 3'b000, 1'b0, 1'b1, 8'd2);
    sw_rst_req = 1'b0;
    expect_at(82, "restart_hold", 3'b000, 1'b0, 1'b1, 8'd2);
    expect_at(83, "restart_dom0", 3'b001, 1'b0, 1'b1, 8'd2);
    expect_at(92, "restart_done", 3'b111, 1'b1, 1'b0, 8'd3);

    // Back-to-back requests keep the sequencer in ASSERT.
    goto(99);
    sw_rst_req = 1'b1;
    expect_at(101, "b2b_mid", 3'b000, 1'b0, 1'b1, 8'd3);
    expect_at(102, "b2b_end", 3'b000, 1'b0, 1'b1, 8'd3);
    sw_rst_req = 1'b0;
    expect_at(109, "b2b_hold", 3'b000, 1'b0, 1'b1, 8'd3);
    expect_at(110, "b2b_dom0", 3'b001, 1'b0, 1'b1, 8'd3);

    // wb_rst_i and sw_rst_req together mid-RELEASE: reset wins, count clears.
    goto(112);
    wb_rst_i   = 1'b1;
    sw_rst_req = 1'b1;
    expect_at(113, "rst_and_req", 3'b000, 1'b0, 1'b1, 8'd0);
    wb_rst_i   = 1'b0;
    sw_rst_req = 1'b0;
    expect_at(121, "post_rst_dom0", 3'b001, 1'b0, 1'b1, 8'd0);
    expect_at(131, "post_rst_done", 3'b111, 1'b1, 1'b0, 8'd1);

    // Run 255 more sequences; the count must saturate at 255.
    for (int i = 0; i < 255; i++) begin
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      repeat (17) tick();
    end
    expect_at(e, "count_sat", 3'b111, 1'b1, 1'b0, 8'd255);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    expect_at(e + 17, "count_stay", 3'b111, 1'b1, 1'b0, 8'd255);

`ifdef XGE_RST_SEQ_ACK_EN
    // Domain 0 never acknowledges: domain 1 waits out the timeout.
    begin
      int base;
      wb_rst_i = 1'b1;
      tick();
      wb_rst_i = 1'b0;
      dom_ack  = 3'b110;
      base     = e;
      expect_at(base + 12,  "ack_wait",   3'b001, 1'b0, 1'b1, 8'd0);
      expect_at(base + 266, "ack_tmo_lo", 3'b001, 1'b0, 1'b1, 8'd0);
      tests++;
      assert (seq_err === 1'b0) else begin
        failed++;
        $error("FAIL ack_err_early seq_err got=%b expected=0", seq_err);
      end
      expect_at(base + 267, "ack_tmo_up", 3'b011, 1'b0, 1'b1, 8'd0);
      tests++;
      assert (seq_err === 1'b1) else begin
        failed++;
        $error("FAIL ack_err_set seq_err got=%b expected=1", seq_err);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/xge_reset_seq.md
Name: xge_reset_seq

Overview:
- Parametrised reset sequencer for the MAC environment.
- Generates one active-low reset per clock domain: 156m25, xgmii_rx, xgmii_tx, and extra domains for multi-port builds.
- Holds all domains in reset for a minimum pulse width, then releases them in fixed, staggered index order.
- Supports software-requested re-sequencing and per-domain hold masks.

Parameters:
- NUM_DOMAINS, 3, number of reset outputs (1..32).
- ASSERT_CYCLES, 8, minimum cycles all outputs are held low (>=1).
- STAGGER_CYCLES, 4, cycles between release of domain k and domain k+1 (>=1).
- CNT_W, 16, width of the internal cycle counter; must hold max(ASSERT_CYCLES, STAGGER_CYCLES).
- TIMEOUT_CYCLES, 256, ack wait limit per domain (used only with XGE_RST_SEQ_ACK_EN).

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- sw_rst_req  in  1  single-cycle request to re-run the full sequence.
- dom_mask  in  NUM_DOMAINS  1 = hold that domain in reset regardless of sequence state.
- rst_n_o  out  NUM_DOMAINS  registered active-low domain resets.
- seq_busy  out  1  high while the sequence is not complete.
- seq_done  out  1  high in DONE state.
- seq_count  out  8  number of completed sequences, saturates at 255.

Behaviour:
- Single clock (wb_clk_i); reset is synchronous and active-high (wb_rst_i).
- While wb_rst_i=1, on every edge: rst_n_o=0, seq_busy=1, seq_done=0, seq_count=0, state=ASSERT, cnt=0, idx=0. sw_rst_req is ignored.
- FSM states: ASSERT, RELEASE, DONE.
- ASSERT:
  - All released[] bits cleared; cnt increments each cycle.
  - When cnt==ASSERT_CYCLES-1: set released[0], clear cnt, idx=1.
  - Next state: DONE if NUM_DOMAINS==1, otherwise RELEASE.
- RELEASE:
  - cnt increments each cycle.
  - When cnt==STAGGER_CYCLES-1: set released[idx], clear cnt.
  - If idx==NUM_DOMAINS-1, go to DONE; otherwise idx++.
- DONE:
  - seq_done=1, seq_busy=0.
  - seq_count increments once on entry; stops incrementing at 255.
- Output: rst_n_o[k] registered as released[k] & ~dom_mask[k].
  - Mask changes take effect on the next edge in any state.
  - A masked domain still consumes its stagger slot, so release timing of the other domains does not depend on the mask.
- Timing (edge 1 = first edge with wb_rst_i=0, no request pending):
  - rst_n_o[k] is high after edge ASSERT_CYCLES + k*STAGGER_CYCLES.
  - seq_done is high after the following edge.
  - Defaults: domain 0 at edge 8, domain 1 at 12, domain 2 at 16, seq_done at 17.
- sw_rst_req=1 in any state: next edge goes to ASSERT with cnt=0, idx=0, all released[] cleared, seq_done=0, seq_busy=1. Effect on rst_n_o is visible after that edge.
  - A request during ASSERT restarts the pulse-width count.
  - Back-to-back requests keep the sequencer in ASSERT.
- Simultaneous wb_rst_i and sw_rst_req: wb_rst_i wins, and seq_count is cleared.
- No glitches: every output is a flop.

Optional Feature:
- Macro: XGE_RST_SEQ_ACK_EN.
- Defined:
  - Adds input dom_ack[NUM_DOMAINS] (domain out-of-reset acknowledge) and output seq_err (sticky).
  - In RELEASE, the release of domain idx requires both cnt>=STAGGER_CYCLES-1 and dom_ack[idx-1]==1.
  - In DONE, domain NUM_DOMAINS-1 must acknowledge before seq_done rises.
  - If the wait exceeds TIMEOUT_CYCLES, seq_err sets and the sequencer proceeds as if acked.
  - Masked domains are treated as acked.
  - seq_err clears only on wb_rst_i or sw_rst_req.
- Not defined: no dom_ack/seq_err ports; fixed-stagger timing exactly as above.

Test Plan:
- Defaults; deassert wb_rst_i -> rst_n_o=3'b000 through edge 7; 3'b001 at edge 8; 3'b011 at 12; 3'b111 at 16; seq_done=1 and seq_count=1 at 17.
- dom_mask=3'b010 during sequence -> rst_n_o[1] stays 0; domain 2 still releases at edge 16. Clear mask at edge 30 -> rst_n_o=3'b111 at edge 31.
- sw_rst_req pulse at edge 40 (DONE) -> rst_n_o=0 after edge 40; domains release at edges 48/52/56; seq_count=2.
- sw_rst_req at edge 5, then again at edge 10 -> domain 0 releases at edge 18, not before.
- wb_rst_i asserted mid-RELEASE with sw_rst_req=1 in the same cycle -> all outputs at reset values next edge; seq_count=0.
- ACK_EN: hold dom_ack[0]=0 -> domain 1 is not released until the timeout elapses, then seq_err=1. Give dom_ack[0] at edge 14 instead -> domain 1 releases at edge 14 or 15, with seq_err=0.
